// File: rtl/gate_check_pkg.sv
// Shared definitions for the truth-table checker: FSM state encoding, function
// codes of the three gate instances under test, and the expected-result helper.
package gate_check_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCheck,
      StFinish
   } state_e;

   localparam int unsigned F_AND    = 0;
   localparam int unsigned F_OR     = 1;
   localparam int unsigned F_XOR    = 2;
   localparam int unsigned N_FUNCS  = 3;
   localparam int unsigned N_COMBOS = 4;

   // Golden result of function f for operands a, b.
   function automatic logic expected_y(input int unsigned f, input logic a, input logic b);
      logic y;
      case (f)
         F_AND:   y = a & b;
         F_OR:    y = a | b;
         F_XOR:   y = a ^ b;
         default: y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Operand/result bus between the checker and the three gate instances.
//   A, B                 operands, driven by the checker (master)
//   Y_AND, Y_OR, Y_XOR   results of the f=0/1/2 instances (slave side)
interface truth_table_checker_if;

   logic A;
   logic B;
   logic Y_AND;
   logic Y_OR;
   logic Y_XOR;

   modport master (
      output A,
      output B,
      input  Y_AND,
      input  Y_OR,
      input  Y_XOR
   );

   modport slave (
      input  A,
      input  B,
      output Y_AND,
      output Y_OR,
      output Y_XOR
   );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long operands are held before sampling.
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load value_i into the counter (takes priority over count_i)
//   value_i      reload value
//   count_i      decrement by one; holds at zero
//   zero_o       counter is zero
module settle_timer #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [Width-1:0] value_i,
   input  logic             count_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (count_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Runs one exhaustive pass over the four {A,B} combinations, holding each for
// SETTLE cycles and then checking the AND/OR/XOR results in a single cycle.
//   CLK, N_RESET          clock, asynchronous active-low reset
//   START                 request a pass (registered before use)
//   gates                 operand/result bus (master side)
//   BUSY                  pass in progress
//   DONE                  pass complete, held until next accepted START
//   PASS_CNT, FAIL_CNT    individual check results of the current/last pass
//   FAIL_MASK             sticky per-function failure flags {XOR, OR, AND}
module truth_table_checker
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE = 2  // legal range 1..15
) (
   input  logic                   CLK,
   input  logic                   N_RESET,
   input  logic                   START,
   truth_table_checker_if.master  gates,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [3:0]             PASS_CNT,
   output logic [3:0]             FAIL_CNT,
   output logic [2:0]             FAIL_MASK
);

   state_e state_q, state_d;

   logic       start_q;
   logic [1:0] ab_q, ab_d;  // {A,B}, doubles as the combination index
   logic [3:0] pass_q, pass_d;
   logic [3:0] fail_q, fail_d;
   logic [2:0] mask_q, mask_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;

   logic       timer_load;
   logic       timer_count;
   logic       settle_zero;

   logic [2:0] miss;
   logic [3:0] miss_cnt;
   logic [3:0] hit_cnt;
   logic       last_combo;

   settle_timer #(
      .Width (4)
   ) u_settle_timer (
      .clk     (CLK),
      .rst_n   (N_RESET),
      .load_i  (timer_load),
      .value_i (4'(SETTLE - 1)),
      .count_i (timer_count),
      .zero_o  (settle_zero)
   );

   // Exact 4-state compare so an X/Z result is never mistaken for a match.
   always_comb begin
      miss[F_AND] = (gates.Y_AND !== expected_y(F_AND, ab_q[1], ab_q[0]));
      miss[F_OR]  = (gates.Y_OR  !== expected_y(F_OR,  ab_q[1], ab_q[0]));
      miss[F_XOR] = (gates.Y_XOR !== expected_y(F_XOR, ab_q[1], ab_q[0]));
   end

   assign miss_cnt   = 4'(miss[0]) + 4'(miss[1]) + 4'(miss[2]);
   assign hit_cnt    = 4'(N_FUNCS) - miss_cnt;
   assign last_combo = (ab_q == 2'(N_COMBOS - 1));

   // State register
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StFinish: if (start_q) state_d = StSettle;
         StSettle:         if (settle_zero) state_d = StCheck;
         StCheck:          state_d = last_combo ? StFinish : StSettle;
         default:          state_d = StIdle;
      endcase
   end

   // Datapath next values and timer control
   always_comb begin
      ab_d        = ab_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      mask_d      = mask_q;
      done_d      = done_q;
      timer_load  = 1'b0;
      timer_count = 1'b0;
      unique case (state_q)
         StIdle, StFinish: begin
            if (start_q) begin
               ab_d       = 2'b00;
               pass_d     = '0;
               fail_d     = '0;
               mask_d     = '0;
               done_d     = 1'b0;
               timer_load = 1'b1;
            end
         end
         StSettle: timer_count = 1'b1;
         StCheck: begin
            pass_d = pass_q + hit_cnt;
            fail_d = fail_q + miss_cnt;
            mask_d = mask_q | miss;
            if (last_combo) begin
               done_d = 1'b1;
            end else begin
               ab_d       = ab_q + 2'd1;
               timer_load = 1'b1;
            end
         end
         default: ;
      endcase
      busy_d = (state_d == StSettle) || (state_d == StCheck);
   end

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         start_q <= 1'b0;
         ab_q    <= 2'b00;
         pass_q  <= '0;
         fail_q  <= '0;
         mask_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         start_q <= START;
         ab_q    <= ab_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         mask_q  <= mask_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign gates.A   = ab_q[1];
   assign gates.B   = ab_q[0];
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign PASS_CNT  = pass_q;
   assign FAIL_CNT  = fail_q;
   assign FAIL_MASK = mask_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

   logic       clk;
   logic       n_reset;
   logic       start;
   logic       start1;
   logic       busy, done, busy1, done1;
   logic [3:0] pass_cnt, fail_cnt, pass_cnt1, fail_cnt1;
   logic [2:0] fail_mask, fail_mask1;

   logic       or_as_and;
   logic       xor_float;
   logic       zval;

   int n_checks;
   int n_pass;

   truth_table_checker_if gif ();
   truth_table_checker_if gif1 ();

   truth_table_checker #(
      .SETTLE (2)
   ) u_dut (
      .CLK       (clk),
      .N_RESET   (n_reset),
      .START     (start),
      .gates     (gif),
      .BUSY      (busy),
      .DONE      (done),
      .PASS_CNT  (pass_cnt),
      .FAIL_CNT  (fail_cnt),
      .FAIL_MASK (fail_mask)
   );

   truth_table_checker #(
      .SETTLE (1)
   ) u_dut1 (
      .CLK       (clk),
      .N_RESET   (n_reset),
      .START     (start1),
      .gates     (gif1),
      .BUSY      (busy1),
      .DONE      (done1),
      .PASS_CNT  (pass_cnt1),
      .FAIL_CNT  (fail_cnt1),
      .FAIL_MASK (fail_mask1)
   );

   // Gate models, with optional faults
   always_comb begin
      gif.Y_AND  = gif.A & gif.B;
      gif.Y_OR   = or_as_and ? (gif.A & gif.B) : (gif.A | gif.B);
      gif.Y_XOR  = xor_float ? zval : (gif.A ^ gif.B);
      gif1.Y_AND = gif1.A & gif1.B;
      gif1.Y_OR  = gif1.A | gif1.B;
      gif1.Y_XOR = gif1.A ^ gif1.B;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Edges after the START edge until DONE is seen; -1 if the bound expires.
   task automatic wait_done(input bit which, input int limit, output int edges);
      edges = 0;
      do begin
         tick();
         edges++;
      end while (((which ? done1 : done) !== 1'b1) && (edges < limit));
      if ((which ? done1 : done) !== 1'b1) edges = -1;
   endtask

   task automatic test_reset();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd0) $display("FAIL reset_pass got %0d want 0", pass_cnt); else n_pass++;
      n_checks++; if (fail_cnt !== 4'd0) $display("FAIL reset_fail got %0d want 0", fail_cnt); else n_pass++;
      n_checks++; if (fail_mask !== 3'b000) $display("FAIL reset_mask got %b want 000", fail_mask); else n_pass++;
      n_checks++; if ({gif.A, gif.B} !== 2'b00) $display("FAIL reset_ab got %b want 00", {gif.A, gif.B}); else n_pass++;
   endtask

   task automatic test_correct_pass();
      logic [1:0] exp_ab [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                   2'd3, 2'd3, 2'd3, 2'd3};
      pulse_start();
      n_checks++; if (busy !== 1'b0) $display("FAIL correct_busy_k got %b want 0", busy); else n_pass++;
      for (int e = 1; e <= 13; e++) begin
         tick();
         n_checks++;
         if ({gif.A, gif.B} !== exp_ab[e-1])
            $display("FAIL correct_ab edge %0d got %b want %b", e, {gif.A, gif.B}, exp_ab[e-1]);
         else n_pass++;
         n_checks++;
         if (busy !== (e <= 12))
            $display("FAIL correct_busy edge %0d got %b want %b", e, busy, (e <= 12));
         else n_pass++;
         n_checks++;
         if (done !== (e == 13))
            $display("FAIL correct_done edge %0d got %b want %b", e, done, (e == 13));
         else n_pass++;
      end
      n_checks++; if (pass_cnt !== 4'd12) $display("FAIL correct_pass got %0d want 12", pass_cnt); else n_pass++;
      n_checks++; if (fail_cnt !== 4'd0) $display("FAIL correct_fail got %0d want 0", fail_cnt); else n_pass++;
      n_checks++; if (fail_mask !== 3'b000) $display("FAIL correct_mask got %b want 000", fail_mask); else n_pass++;
   endtask

   task automatic test_or_as_and();
      int edges;
      or_as_and = 1'b1;
      pulse_start();
      wait_done(1'b0, 40, edges);
      n_checks++; if (edges != 13) $display("FAIL orand_latency got %0d want 13", edges); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd10) $display("FAIL orand_pass got %0d want 10", pass_cnt); else n_pass++;
      n_checks++; if (fail_cnt !== 4'd2) $display("FAIL orand_fail got %0d want 2", fail_cnt); else n_pass++;
      n_checks++; if (fail_mask !== 3'b010) $display("FAIL orand_mask got %b want 010", fail_mask); else n_pass++;
      or_as_and = 1'b0;
   endtask

   task automatic test_xor_float();
      int edges;
      logic [3:0] exp_pass, exp_fail;
      // A floating result fails on every combo; if the simulator collapses z to 0
      // only the combos expecting 1 (01 and 10) can fail.
      if (zval === 1'bz) begin
         exp_pass = 4'd8;  exp_fail = 4'd4;
      end else begin
         exp_pass = 4'd10; exp_fail = 4'd2;
      end
      xor_float = 1'b1;
      pulse_start();
      wait_done(1'b0, 40, edges);
      n_checks++; if (edges != 13) $display("FAIL xorz_latency got %0d want 13", edges); else n_pass++;
      n_checks++; if (pass_cnt !== exp_pass) $display("FAIL xorz_pass got %0d want %0d", pass_cnt, exp_pass); else n_pass++;
      n_checks++; if (fail_cnt !== exp_fail) $display("FAIL xorz_fail got %0d want %0d", fail_cnt, exp_fail); else n_pass++;
      n_checks++; if (fail_mask !== 3'b100) $display("FAIL xorz_mask got %b want 100", fail_mask); else n_pass++;
      xor_float = 1'b0;
   endtask

   task automatic test_restart_ignored();
      int edges;
      pulse_start();
      tick();
      tick();
      start = 1'b1;  // sampled at relative edge 3
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      start = 1'b1;  // sampled at relative edge 7
      tick();
      start = 1'b0;
      wait_done(1'b0, 40, edges);
      edges = (edges < 0) ? edges : edges + 7;
      n_checks++; if (edges != 13) $display("FAIL restart_latency got %0d want 13", edges); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd12) $display("FAIL restart_pass got %0d want 12", pass_cnt); else n_pass++;
      n_checks++; if (fail_cnt !== 4'd0) $display("FAIL restart_fail got %0d want 0", fail_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_pass();
      int edges;
      pulse_start();
      for (int i = 0; i < 6; i++) tick();
      n_reset = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd0) $display("FAIL midrst_pass got %0d want 0", pass_cnt); else n_pass++;
      n_checks++; if (fail_mask !== 3'b000) $display("FAIL midrst_mask got %b want 000", fail_mask); else n_pass++;
      n_checks++; if ({gif.A, gif.B} !== 2'b00) $display("FAIL midrst_ab got %b want 00", {gif.A, gif.B}); else n_pass++;
      tick();
      tick();
      n_reset = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      n_checks++; if (done !== 1'b0) $display("FAIL midrst_idle_done got %b want 0", done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_idle_busy got %b want 0", busy); else n_pass++;
      pulse_start();
      wait_done(1'b0, 40, edges);
      n_checks++; if (edges != 13) $display("FAIL midrst_rerun_latency got %0d want 13", edges); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd12) $display("FAIL midrst_rerun_pass got %0d want 12", pass_cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int edges;
      n_checks++; if (done !== 1'b1) $display("FAIL b2b_pre_done got %b want 1", done); else n_pass++;
      pulse_start();
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_clear got %b want 0", done); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd0) $display("FAIL b2b_pass_clear got %0d want 0", pass_cnt); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else n_pass++;
      wait_done(1'b0, 40, edges);
      edges = (edges < 0) ? edges : edges + 1;
      n_checks++; if (edges != 13) $display("FAIL b2b_latency got %0d want 13", edges); else n_pass++;
      n_checks++; if (pass_cnt !== 4'd12) $display("FAIL b2b_pass got %0d want 12", pass_cnt); else n_pass++;
   endtask

   task automatic test_settle_one();
      int edges;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(1'b1, 40, edges);
      n_checks++; if (edges != 9) $display("FAIL settle1_latency got %0d want 9", edges); else n_pass++;
      n_checks++; if (pass_cnt1 !== 4'd12) $display("FAIL settle1_pass got %0d want 12", pass_cnt1); else n_pass++;
      n_checks++; if (fail_cnt1 !== 4'd0) $display("FAIL settle1_fail got %0d want 0", fail_cnt1); else n_pass++;
      n_checks++; if (busy1 !== 1'b0) $display("FAIL settle1_busy got %b want 0", busy1); else n_pass++;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_reset   = 1'b0;
      start     = 1'b0;
      start1    = 1'b0;
      or_as_and = 1'b0;
      xor_float = 1'b0;
      zval      = 1'bz;
      #12;
      test_reset();
      tick();
      n_reset = 1'b1;
      tick();
      test_correct_pass();
      test_or_as_and();
      test_xor_float();
      test_restart_ignored();
      test_reset_mid_pass();
      test_back_to_back();
      test_settle_one();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
